// File: rtl/controle_fsm_multiciclo_if.sv
// Control bundle between the multicycle FSM and the 16-bit datapath:
// instruction/status coming in, enables, bus selects and handshake going out.
interface controle_fsm_multiciclo_if;
   logic        Run;
   logic [8:0]  Instrucao;
   logic [15:0] GRout;
   logic        IRin;
   logic [7:0]  Rin;
   logic [7:0]  Rout;
   logic        Ain;
   logic        Gin;
   logic        Gout;
   logic        DINout;
   logic [1:0]  Ulaop;
   logic        ADDRin;
   logic        DOUTin;
   logic        W_D;
   logic        IncrPc;
   logic        Done;
   logic [2:0]  Tstep;

   // Controller side: drives every datapath enable.
   modport master (
      input  Run, Instrucao, GRout,
      output IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop,
             ADDRin, DOUTin, W_D, IncrPc, Done, Tstep
   );

   // Datapath / environment side.
   modport slave (
      output Run, Instrucao, GRout,
      input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop,
             ADDRin, DOUTin, W_D, IncrPc, Done, Tstep
   );
endinterface

// File: rtl/controle_fsm_multiciclo.sv
// Control FSM of the 16-bit multicycle processor: fetches III_XXX_YYY from
// synchronous RAM, decodes it and sequences the datapath enables.
module controle_fsm_multiciclo #(
   parameter logic [1:0] ULA_ADD = 2'b00,
   parameter logic [1:0] ULA_SUB = 2'b01
) (
   input  logic                       Clock,
   input  logic                       Reset,
   controle_fsm_multiciclo_if.master  ctl
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      F0   = 3'd1,
      F1   = 3'd2,
      F2   = 3'd3,
      E1   = 3'd4,
      E2   = 3'd5,
      E3   = 3'd6
   } state_t;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_LD   = 3'b100;
   localparam logic [2:0] OP_ST   = 3'b101;
   localparam logic [2:0] OP_MVNZ = 3'b110;

   state_t     state_q;
   state_t     state_d;
   logic       done_c;
   logic [2:0] opcode;
   logic [2:0] rx;
   logic [2:0] ry;

   assign opcode = ctl.Instrucao[8:6];
   assign rx     = ctl.Instrucao[5:3];
   assign ry     = ctl.Instrucao[2:0];

   // Register number n maps to bit 7-n (R0 is the MSB, R7 the LSB).
   function automatic logic [7:0] reg_sel(input logic [2:0] r);
      return 8'b1000_0000 >> r;
   endfunction

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   assign ctl.Tstep = state_q;

   always_comb begin
      state_d    = IDLE;
      done_c     = 1'b0;
      ctl.IRin   = 1'b0;
      ctl.Rin    = 8'h00;
      ctl.Rout   = 8'h00;
      ctl.Ain    = 1'b0;
      ctl.Gin    = 1'b0;
      ctl.Gout   = 1'b0;
      ctl.DINout = 1'b0;
      ctl.Ulaop  = ULA_ADD;
      ctl.ADDRin = 1'b0;
      ctl.DOUTin = 1'b0;
      ctl.W_D    = 1'b0;
      ctl.IncrPc = 1'b0;

      case (state_q)
         IDLE: state_d = ctl.Run ? F0 : IDLE;
         F0: begin
            ctl.Rout   = reg_sel(3'd7);
            ctl.ADDRin = 1'b1;
            ctl.IncrPc = 1'b1;
            state_d    = F1;
         end
         F1: state_d = F2;
         F2: begin
            ctl.IRin = 1'b1;
            state_d  = E1;
         end
         E1: begin
            state_d = E2;
            case (opcode)
               OP_MV: begin
                  ctl.Rout = reg_sel(ry);
                  ctl.Rin  = reg_sel(rx);
                  done_c   = 1'b1;
               end
               OP_MVI: begin
                  ctl.Rout   = reg_sel(3'd7);
                  ctl.ADDRin = 1'b1;
                  ctl.IncrPc = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctl.Rout = reg_sel(rx);
                  ctl.Ain  = 1'b1;
               end
               OP_LD, OP_ST: begin
                  ctl.Rout   = reg_sel(ry);
                  ctl.ADDRin = 1'b1;
               end
               OP_MVNZ: begin
                  if (|ctl.GRout) begin
                     ctl.Rout = reg_sel(ry);
                     ctl.Rin  = reg_sel(rx);
                  end
                  done_c = 1'b1;
               end
               default: done_c = 1'b1;
            endcase
         end
         E2: begin
            state_d = E3;
            case (opcode)
               OP_ADD, OP_SUB: begin
                  ctl.Rout  = reg_sel(ry);
                  ctl.Gin   = 1'b1;
                  ctl.Ulaop = (opcode == OP_SUB) ? ULA_SUB : ULA_ADD;
               end
               OP_ST: begin
                  ctl.Rout   = reg_sel(rx);
                  ctl.DOUTin = 1'b1;
               end
               default: ;
            endcase
         end
         E3: begin
            done_c = 1'b1;
            case (opcode)
               OP_MVI, OP_LD: begin
                  ctl.DINout = 1'b1;
                  ctl.Rin    = reg_sel(rx);
               end
               OP_ADD, OP_SUB: begin
                  ctl.Gout = 1'b1;
                  ctl.Rin  = reg_sel(rx);
               end
               OP_ST:   ctl.W_D = 1'b1;
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase

      // Run is only sampled here and in IDLE, so back-to-back fetch skips IDLE.
      if (done_c) state_d = ctl.Run ? F0 : IDLE;
      ctl.Done = done_c;
   end

   // Bus and write-enable sanity: one bus driver, one destination register.
   a_rout_onehot: assert property (@(posedge Clock) disable iff (Reset)
      $onehot0(ctl.Rout));
   a_single_source: assert property (@(posedge Clock) disable iff (Reset)
      $onehot0({|ctl.Rout, ctl.Gout, ctl.DINout}));
   a_rin_onehot: assert property (@(posedge Clock) disable iff (Reset)
      $onehot0(ctl.Rin));
   a_pc_conflict: assert property (@(posedge Clock) disable iff (Reset)
      !(ctl.IncrPc && ctl.Rin[0]));
   a_ulaop_idle: assert property (@(posedge Clock) disable iff (Reset)
      ctl.Gin || (ctl.Ulaop == ULA_ADD));

endmodule

// File: tb/tb_controle_fsm_multiciclo.sv
// Bench for controle_fsm_multiciclo: a behavioural datapath runs the program
// under FSM control and is compared to an instruction-level model.
module tb_controle_fsm_multiciclo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   controle_fsm_multiciclo_if ifc ();
   controle_fsm_multiciclo dut (.Clock(clk), .Reset(rst), .ctl(ifc));

   // Datapath driven by the controller outputs.
   logic [15:0] dp_r [8];
   logic [15:0] dp_mem [256];
   logic [15:0] dp_a, dp_g, dp_addr, dp_dout, dp_din, dp_bus;
   logic [8:0]  dp_ir;
   logic        dp_clr, ld_en;
   logic [7:0]  ld_addr;
   logic [15:0] ld_data;

   always_comb begin
      dp_bus = 16'h0000;
      if (ifc.Gout) dp_bus = dp_g;
      else if (ifc.DINout) dp_bus = dp_din;
      else for (int i = 0; i < 8; i++) if (ifc.Rout[7-i]) dp_bus = dp_r[i];
   end

   assign ifc.Instrucao = dp_ir;
   assign ifc.GRout     = dp_g;

   always @(posedge clk) begin
      if (dp_clr) begin
         for (int i = 0; i < 8; i++) dp_r[i] <= 16'h0000;
         dp_a <= 16'h0; dp_g <= 16'h0; dp_addr <= 16'h0;
         dp_dout <= 16'h0; dp_din <= 16'h0; dp_ir <= 9'h0;
      end else begin
         for (int i = 0; i < 8; i++) if (ifc.Rin[7-i]) dp_r[i] <= dp_bus;
         if (ifc.IncrPc) dp_r[7] <= dp_r[7] + 16'd1;
         if (ifc.Ain)    dp_a <= dp_bus;
         if (ifc.Gin)    dp_g <= (ifc.Ulaop == 2'b01) ? dp_a - dp_bus : dp_a + dp_bus;
         if (ifc.ADDRin) dp_addr <= dp_bus;
         if (ifc.DOUTin) dp_dout <= dp_bus;
         if (ifc.IRin)   dp_ir <= dp_din[8:0];
         if (ifc.W_D)    dp_mem[dp_addr[7:0]] <= dp_dout;
         dp_din <= dp_mem[dp_addr[7:0]];
      end
      if (ld_en) dp_mem[ld_addr] <= ld_data;
   end

   // Instruction-level reference state.
   logic [15:0] m_r [8];
   logic [15:0] m_g;
   logic [15:0] m_mem [256];
   logic [15:0] img [256];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({ifc.IRin, ifc.Rin, ifc.Rout, ifc.Ain, ifc.Gin, ifc.Gout, ifc.DINout,
                  ifc.Ulaop, ifc.ADDRin, ifc.DOUTin, ifc.W_D, ifc.IncrPc, ifc.Done});
   endfunction

   function automatic logic [31:0] inv_bits();
      logic [4:0] v;
      int srcs;
      srcs = int'(|ifc.Rout) + int'(ifc.Gout) + int'(ifc.DINout);
      v[0] = !$onehot0(ifc.Rout);
      v[1] = srcs > 1;
      v[2] = !$onehot0(ifc.Rin);
      v[3] = !ifc.Gin && (ifc.Ulaop != 2'b00);
      v[4] = ifc.IncrPc && ifc.Rin[0];
      return 32'(v);
   endfunction

   // One instruction executed with plain arithmetic; returns its cycle count.
   task automatic model_step(output int n, output logic wr, output logic [7:0] wa,
                             output logic [2:0] op);
      logic [15:0] pc, w;
      logic [2:0]  x, y;
      pc = m_r[7];
      w  = m_mem[pc[7:0]];
      op = w[8:6]; x = w[5:3]; y = w[2:0];
      m_r[7] = pc + 16'd1;
      wr = 1'b0; wa = 8'h00; n = 6;
      case (op)
         3'd0: begin m_r[x] = m_r[y]; n = 4; end
         3'd1: begin
            w = m_mem[m_r[7][7:0]];
            m_r[7] = m_r[7] + 16'd1;
            m_r[x] = w;
         end
         3'd2: begin m_g = m_r[x] + m_r[y]; m_r[x] = m_g; end
         3'd3: begin m_g = m_r[x] - m_r[y]; m_r[x] = m_g; end
         3'd4: m_r[x] = m_mem[m_r[y][7:0]];
         3'd5: begin wa = m_r[y][7:0]; m_mem[wa] = m_r[x]; wr = 1'b1; end
         3'd6: begin if (m_g != 16'h0) m_r[x] = m_r[y]; n = 4; end
         default: n = 4;
      endcase
   endtask

   task automatic run_instr(input logic stop);
      int n;
      logic wr, run_nxt;
      logic [7:0] wa;
      logic [2:0] op;
      run_nxt = 1'b0;
      model_step(n, wr, wa, op);
      if (ifc.Tstep == 3'd0) begin
         ifc.Run = 1'b1;
         @(posedge clk); #1;
      end
      for (int k = 0; k < n; k++) begin
         chk("tstep", 32'(ifc.Tstep), 32'(k + 1));
         chk("done", 32'(ifc.Done), 32'(k == n - 1));
         chk("w_d", 32'(ifc.W_D), 32'(op == 3'd5 && k == 5));
         chk("invariants", inv_bits(), 32'h0);
         if (k == n - 1) begin
            run_nxt = stop ? 1'b0 : ($urandom_range(3) != 0);
            ifc.Run = run_nxt;
         end else begin
            ifc.Run = 1'($urandom_range(1));
         end
         @(posedge clk); #1;
      end
      if (!run_nxt) begin
         chk("idle_tstep", 32'(ifc.Tstep), 32'h0);
         chk("idle_outputs", out_vec(), 32'h0);
      end
      for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), 32'(dp_r[i]), 32'(m_r[i]));
      chk("g", 32'(dp_g), 32'(m_g));
      if (wr) chk("mem_store", 32'(dp_mem[wa]), 32'(m_mem[wa]));
   endtask

   initial begin
      logic [15:0] pc, old;
      logic [7:0]  tgt;
      rst = 1'b1; ifc.Run = 1'b0; dp_clr = 1'b1; ld_en = 1'b0;
      ld_addr = 8'h00; ld_data = 16'h0000;

      for (int a = 0; a < 256; a++) img[a] = 16'($urandom);
      img[0]  = {7'd0, 3'b001, 3'd0, 3'd0}; img[1]  = 16'd5;     // mvi R0,5
      img[2]  = {7'd0, 3'b001, 3'd1, 3'd0}; img[3]  = 16'd3;     // mvi R1,3
      img[4]  = {7'd0, 3'b010, 3'd0, 3'd1};                      // add R0,R1
      img[5]  = {7'd0, 3'b011, 3'd0, 3'd1};                      // sub R0,R1
      img[6]  = {7'd0, 3'b001, 3'd2, 3'd0}; img[7]  = 16'h00AB;  // mvi R2,AB
      img[8]  = {7'd0, 3'b001, 3'd3, 3'd0}; img[9]  = 16'd200;   // mvi R3,200
      img[10] = {7'd0, 3'b101, 3'd2, 3'd3};                      // st R2,[R3]
      img[11] = {7'd0, 3'b100, 3'd4, 3'd3};                      // ld R4,[R3]
      img[12] = {7'd0, 3'b011, 3'd1, 3'd1};                      // sub R1,R1
      img[13] = {7'd0, 3'b110, 3'd5, 3'd6};                      // mvnz R5,R6
      img[14] = {7'd0, 3'b001, 3'd6, 3'd0}; img[15] = 16'd7;     // mvi R6,7
      img[16] = {7'd0, 3'b010, 3'd2, 3'd3};                      // add R2,R3
      img[17] = {7'd0, 3'b110, 3'd5, 3'd6};                      // mvnz R5,R6

      repeat (2) @(posedge clk);
      #1;
      dp_clr = 1'b0;
      chk("reset_tstep", 32'(ifc.Tstep), 32'h0);
      chk("reset_outputs", out_vec(), 32'h0);

      ifc.Run = 1'b1;
      for (int a = 0; a < 256; a++) begin
         ld_en = 1'b1; ld_addr = 8'(a); ld_data = img[a]; m_mem[a] = img[a];
         @(posedge clk); #1;
      end
      ld_en = 1'b0;
      chk("reset_hold_run", 32'(ifc.Tstep), 32'h0);
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
      m_g = 16'h0;

      ifc.Run = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_no_run", 32'(ifc.Tstep), 32'h0);
      chk("idle_no_run_out", out_vec(), 32'h0);

      for (int i = 0; i < 13; i++) begin
         run_instr(1'b0);
         case (i)
            0: begin chk("mvi_r0", 32'(dp_r[0]), 32'd5); chk("mvi_r7", 32'(dp_r[7]), 32'd2); end
            2: chk("add_r0", 32'(dp_r[0]), 32'd8);
            3: chk("sub_r0", 32'(dp_r[0]), 32'd5);
            7: begin chk("st_mem", 32'(dp_mem[200]), 32'h00AB); chk("ld_r4", 32'(dp_r[4]), 32'h00AB); end
            9: chk("mvnz_zero", 32'(dp_r[5]), 32'd0);
            12: chk("mvnz_nonzero", 32'(dp_r[5]), 32'd7);
            default: ;
         endcase
      end

      for (int i = 0; i < 400; i++) run_instr(i == 399);

      // Reset asserted in E2 of a store.
      pc  = m_r[7];
      tgt = m_r[3][7:0];
      ld_en = 1'b1; ld_addr = pc[7:0]; ld_data = {7'd0, 3'b101, 3'd2, 3'd3};
      m_mem[pc[7:0]] = ld_data;
      @(posedge clk); #1;
      ld_en = 1'b0;
      old = m_mem[tgt];
      ifc.Run = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("st_reached_e2", 32'(ifc.Tstep), 32'd5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_reset_tstep", 32'(ifc.Tstep), 32'h0);
      chk("async_reset_out", out_vec(), 32'h0);
      ifc.Run = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk("reset_w_d", 32'(ifc.W_D), 32'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abandoned_mem", 32'(dp_mem[tgt]), 32'(old));
      chk("abandoned_r7", 32'(dp_r[7]), 32'(pc + 16'd1));
      m_r[7] = pc + 16'd1;
      for (int i = 0; i < 3; i++) run_instr(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
